heap_alloc: RTL and testbench



---
 rtl/heap_alloc_if.sv | 33 +++
 rtl/heap_alloc.sv | 190 +++++++++++++++++++
 tb/tb_heap_alloc.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/heap_alloc_if.sv
// heap_alloc_if: pointer port (alloc/free), access port (read/write) and
// status outputs of the heap allocator, bundled as one bus.
interface heap_alloc_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
);
    logic               i_al;
    logic [DATA_SZ-1:0] i_adata;
    logic [DATA_SZ-1:0] o_aaddr;
    logic               i_fr;
    logic [DATA_SZ-1:0] i_faddr;
    logic               i_wr;
    logic [DATA_SZ-1:0] i_waddr;
    logic [DATA_SZ-1:0] i_wdata;
    logic               i_rd;
    logic [DATA_SZ-1:0] i_raddr;
    logic [DATA_SZ-1:0] o_rdata;
    logic               o_full;
    logic [ADDR_SZ:0]   o_free_cnt;
    logic [ADDR_SZ:0]   o_used_cnt;
    logic               o_err;
    logic [1:0]         o_err_code;

    modport slave (
        input  i_al, i_adata, i_fr, i_faddr, i_wr, i_waddr, i_wdata, i_rd, i_raddr,
        output o_aaddr, o_rdata, o_full, o_free_cnt, o_used_cnt, o_err, o_err_code
    );

    modport master (
        output i_al, i_adata, i_fr, i_faddr, i_wr, i_waddr, i_wdata, i_rd, i_raddr,
        input  o_aaddr, o_rdata, o_full, o_free_cnt, o_used_cnt, o_err, o_err_code
    );
endinterface

// File: rtl/heap_alloc.sv
// heap_alloc: linked-memory heap allocator. Cells are handed out from a bump
// pointer (top) until exhausted, freed cells form a LIFO list linked through
// the cells themselves. Any error halts the block until reset.
module heap_alloc #(
    parameter int                 DATA_SZ  = 16,
    parameter int                 ADDR_SZ  = 8,
    parameter int                 MEM_MAX  = 1 << ADDR_SZ,
    parameter logic [DATA_SZ-1:0] BASE_TAG = 16'h5000
) (
    input logic         i_clk,
    input logic         i_rst,
    heap_alloc_if.slave bus
);
    localparam int CNT_W = ADDR_SZ + 1;
    localparam int DEPTH = 1 << ADDR_SZ;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [ADDR_SZ-1:0] off_t;
    typedef logic [DATA_SZ-1:0] word_t;

    localparam cnt_t  MEM_MAX_C = cnt_t'(MEM_MAX);
    localparam cnt_t  ONE       = cnt_t'(1);
    localparam word_t NIL       = word_t'(1);

    localparam logic [1:0] E_NONE     = 2'd0;
    localparam logic [1:0] E_CONFLICT = 2'd1;
    localparam logic [1:0] E_OOM      = 2'd2;
    localparam logic [1:0] E_BADADDR  = 2'd3;

    typedef enum logic {S_RUN, S_HALT} state_t;

    // Cell offset of a tagged heap address.
    function automatic off_t off_of(input word_t addr);
        return addr[ADDR_SZ-1:0];
    endfunction

    // Tagged heap address of a cell offset.
    function automatic word_t tag_addr(input off_t off);
        return BASE_TAG | word_t'(off);
    endfunction

    // Address carries the heap tag and points below the bump pointer.
    function automatic logic addr_ok(input word_t addr, input cnt_t top);
        return (addr[DATA_SZ-1:ADDR_SZ] == BASE_TAG[DATA_SZ-1:ADDR_SZ]) &&
               ({1'b0, addr[ADDR_SZ-1:0]} < top);
    endfunction

    word_t  mem [0:DEPTH-1];

    state_t state_q, state_n;
    cnt_t   top_q, top_n;
    cnt_t   free_q, free_n;
    cnt_t   used_q, used_n;
    logic   full_q, full_n;
    logic [1:0] code_q, code_n;
    word_t  aaddr_q, aaddr_n;
    word_t  head_q, head_n;
    logic   link_vld_p1, link_vld_n;
    word_t  link_p1;
    word_t  rdata_p1;
    word_t  eff_head;

    logic   mem_we;
    off_t   mem_wa;
    word_t  mem_wd;
    off_t   link_ra;
    logic   rd_en;

    logic   conflict, bad_addr, oom;

    // A link read on the previous pop is the true head until it is captured.
    assign eff_head = link_vld_p1 ? link_p1 : head_q;

    assign conflict = (bus.i_al | bus.i_fr) & (bus.i_wr | bus.i_rd);
    assign bad_addr = (bus.i_fr & ~addr_ok(bus.i_faddr, top_q)) |
                      (bus.i_wr & ~addr_ok(bus.i_waddr, top_q)) |
                      (bus.i_rd & ~addr_ok(bus.i_raddr, top_q));
    assign oom      = bus.i_al & ~bus.i_fr & (free_q == '0) & (top_q == MEM_MAX_C);

    // Next-state, counter and memory-port decode for one request cycle.
    always_comb begin
        state_n    = state_q;
        top_n      = top_q;
        free_n     = free_q;
        used_n     = used_q;
        code_n     = code_q;
        aaddr_n    = '0;
        head_n     = eff_head;
        link_vld_n = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = '0;
        mem_wd     = '0;
        link_ra    = off_of(eff_head);
        rd_en      = 1'b0;

        if (!i_rst && state_q == S_RUN) begin
            if (conflict) begin
                state_n = S_HALT;
                code_n  = E_CONFLICT;
            end else if (bad_addr) begin
                state_n = S_HALT;
                code_n  = E_BADADDR;
            end else if (oom) begin
                state_n = S_HALT;
                code_n  = E_OOM;
            end else if (bus.i_al && bus.i_fr) begin
                // Freed cell is reused directly; the free list is untouched.
                mem_we  = 1'b1;
                mem_wa  = off_of(bus.i_faddr);
                mem_wd  = bus.i_adata;
                aaddr_n = bus.i_faddr;
            end else if (bus.i_al) begin
                mem_we = 1'b1;
                mem_wd = bus.i_adata;
                used_n = used_q + ONE;
                if (free_q != '0) begin
                    // Pop: the old cell content is the next link, read
                    // before the initial data overwrites it.
                    mem_wa     = off_of(eff_head);
                    link_vld_n = 1'b1;
                    aaddr_n    = eff_head;
                    free_n     = free_q - ONE;
                end else begin
                    mem_wa  = top_q[ADDR_SZ-1:0];
                    aaddr_n = tag_addr(top_q[ADDR_SZ-1:0]);
                    top_n   = top_q + ONE;
                end
            end else if (bus.i_fr) begin
                mem_we = 1'b1;
                mem_wa = off_of(bus.i_faddr);
                mem_wd = eff_head;
                head_n = bus.i_faddr;
                free_n = free_q + ONE;
                used_n = used_q - ONE;
            end else begin
                if (bus.i_wr) begin
                    mem_we = 1'b1;
                    mem_wa = off_of(bus.i_waddr);
                    mem_wd = bus.i_wdata;
                end
                rd_en = bus.i_rd;
            end
        end

        full_n = (top_n == MEM_MAX_C) && (free_n == '0);
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_RUN;
            top_q       <= '0;
            free_q      <= '0;
            used_q      <= '0;
            full_q      <= 1'b0;
            code_q      <= E_NONE;
            aaddr_q     <= '0;
            head_q      <= NIL;
            link_vld_p1 <= 1'b0;
        end else begin
            state_q     <= state_n;
            top_q       <= top_n;
            free_q      <= free_n;
            used_q      <= used_n;
            full_q      <= full_n;
            code_q      <= code_n;
            aaddr_q     <= aaddr_n;
            head_q      <= head_n;
            link_vld_p1 <= link_vld_n;
        end
    end

    // Heap BRAM: one write port, link read port and access read port.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
        link_p1 <= mem[link_ra];
        if (rd_en) begin
            rdata_p1 <= mem[off_of(bus.i_raddr)];
        end
    end

    assign bus.o_aaddr    = aaddr_q;
    assign bus.o_rdata    = rdata_p1;
    assign bus.o_full     = full_q;
    assign bus.o_free_cnt = free_q;
    assign bus.o_used_cnt = used_q;
    assign bus.o_err      = (state_q == S_HALT);
    assign bus.o_err_code = code_q;
endmodule

// File: tb/tb_heap_alloc.sv
// tb_heap_alloc: directed tests of heap_alloc; dut0 uses the default 256-cell
// heap, dut1 an 8-cell heap for the exhaustion case.
module tb_heap_alloc;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(8)) b0();
    heap_alloc_if #(.DATA_SZ(16), .ADDR_SZ(3)) b1();

    heap_alloc #(.DATA_SZ(16), .ADDR_SZ(8), .MEM_MAX(256), .BASE_TAG(16'h5000))
        dut0 (.i_clk(clk), .i_rst(rst0), .bus(b0));
    heap_alloc #(.DATA_SZ(16), .ADDR_SZ(3), .MEM_MAX(8), .BASE_TAG(16'h5000))
        dut1 (.i_clk(clk), .i_rst(rst1), .bus(b1));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        b0.i_al = 0; b0.i_adata = 0; b0.i_fr = 0; b0.i_faddr = 0;
        b0.i_wr = 0; b0.i_waddr = 0; b0.i_wdata = 0; b0.i_rd = 0; b0.i_raddr = 0;
    endtask

    task automatic idle1();
        b1.i_al = 0; b1.i_adata = 0; b1.i_fr = 0; b1.i_faddr = 0;
        b1.i_wr = 0; b1.i_waddr = 0; b1.i_wdata = 0; b1.i_rd = 0; b1.i_raddr = 0;
    endtask

    task automatic reset0();
        rst0 = 1; idle0(); cyc(); rst0 = 0;
    endtask

    task automatic test_reset();
        idle0(); idle1();
        rst0 = 1; rst1 = 1;
        b0.i_al = 1; b0.i_adata = 16'h0099;
        cyc();
        rst0 = 0; rst1 = 0; idle0();
        checks++; if (b0.o_aaddr !== 16'h0) begin errors++; $display("FAIL rst_aaddr got %h want %h", b0.o_aaddr, 16'h0); end
        checks++; if (b0.o_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", b0.o_err); end
        checks++; if (b0.o_err_code !== 2'd0) begin errors++; $display("FAIL rst_code got %0d want 0", b0.o_err_code); end
        checks++; if (b0.o_full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", b0.o_full); end
        checks++; if (b0.o_free_cnt !== 9'd0) begin errors++; $display("FAIL rst_free got %0d want 0", b0.o_free_cnt); end
        checks++; if (b0.o_used_cnt !== 9'd0) begin errors++; $display("FAIL rst_used got %0d want 0", b0.o_used_cnt); end
    endtask

    task automatic test_alloc();
        b0.i_al = 1; b0.i_adata = 16'h000A; cyc();
        checks++; if (b0.o_aaddr !== 16'h5000) begin errors++; $display("FAIL alloc0 got %h want 5000", b0.o_aaddr); end
        b0.i_adata = 16'h000B; cyc();
        checks++; if (b0.o_aaddr !== 16'h5001) begin errors++; $display("FAIL alloc1 got %h want 5001", b0.o_aaddr); end
        b0.i_adata = 16'h000C; cyc();
        b0.i_al = 0;
        checks++; if (b0.o_aaddr !== 16'h5002) begin errors++; $display("FAIL alloc2 got %h want 5002", b0.o_aaddr); end
        checks++; if (b0.o_used_cnt !== 9'd3) begin errors++; $display("FAIL alloc_used got %0d want 3", b0.o_used_cnt); end
        checks++; if (b0.o_free_cnt !== 9'd0) begin errors++; $display("FAIL alloc_free got %0d want 0", b0.o_free_cnt); end
        b0.i_rd = 1; b0.i_raddr = 16'h5000; cyc();
        checks++; if (b0.o_rdata !== 16'h000A) begin errors++; $display("FAIL rd5000 got %h want 000a", b0.o_rdata); end
        checks++; if (b0.o_aaddr !== 16'h0) begin errors++; $display("FAIL idle_aaddr got %h want 0", b0.o_aaddr); end
        b0.i_raddr = 16'h5001; cyc();
        checks++; if (b0.o_rdata !== 16'h000B) begin errors++; $display("FAIL rd5001 got %h want 000b", b0.o_rdata); end
        b0.i_raddr = 16'h5002; cyc();
        b0.i_rd = 0;
        checks++; if (b0.o_rdata !== 16'h000C) begin errors++; $display("FAIL rd5002 got %h want 000c", b0.o_rdata); end
    endtask

    task automatic test_free_pop();
        b0.i_fr = 1; b0.i_faddr = 16'h5001; cyc();
        checks++; if (b0.o_aaddr !== 16'h0) begin errors++; $display("FAIL free_aaddr got %h want 0", b0.o_aaddr); end
        checks++; if (b0.o_free_cnt !== 9'd1 || b0.o_used_cnt !== 9'd2) begin errors++; $display("FAIL free1_cnt got free %0d used %0d want 1 2", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_faddr = 16'h5000; cyc();
        b0.i_fr = 0;
        checks++; if (b0.o_free_cnt !== 9'd2 || b0.o_used_cnt !== 9'd1) begin errors++; $display("FAIL free2_cnt got free %0d used %0d want 2 1", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_al = 1; b0.i_adata = 16'h0011; cyc();
        checks++; if (b0.o_aaddr !== 16'h5000) begin errors++; $display("FAIL pop0 got %h want 5000", b0.o_aaddr); end
        b0.i_adata = 16'h0022; cyc();
        checks++; if (b0.o_aaddr !== 16'h5001) begin errors++; $display("FAIL pop1_b2b got %h want 5001", b0.o_aaddr); end
        checks++; if (b0.o_free_cnt !== 9'd0 || b0.o_used_cnt !== 9'd3) begin errors++; $display("FAIL pop_cnt got free %0d used %0d want 0 3", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_adata = 16'h0033; cyc();
        b0.i_al = 0;
        checks++; if (b0.o_aaddr !== 16'h5003) begin errors++; $display("FAIL top_alloc got %h want 5003", b0.o_aaddr); end
        checks++; if (b0.o_used_cnt !== 9'd4) begin errors++; $display("FAIL top_used got %0d want 4", b0.o_used_cnt); end
    endtask

    task automatic test_alloc_free();
        b0.i_al = 1; b0.i_fr = 1; b0.i_faddr = 16'h5002; b0.i_adata = 16'h0077; cyc();
        idle0();
        checks++; if (b0.o_aaddr !== 16'h5002) begin errors++; $display("FAIL af_aaddr got %h want 5002", b0.o_aaddr); end
        checks++; if (b0.o_free_cnt !== 9'd0 || b0.o_used_cnt !== 9'd4) begin errors++; $display("FAIL af_cnt got free %0d used %0d want 0 4", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_rd = 1; b0.i_raddr = 16'h5002; cyc();
        b0.i_rd = 0;
        checks++; if (b0.o_rdata !== 16'h0077) begin errors++; $display("FAIL af_rd got %h want 0077", b0.o_rdata); end
    endtask

    task automatic test_link_across_read();
        b0.i_fr = 1; b0.i_faddr = 16'h5000; cyc();
        b0.i_faddr = 16'h5002; cyc();
        b0.i_fr = 0;
        checks++; if (b0.o_free_cnt !== 9'd2 || b0.o_used_cnt !== 9'd2) begin errors++; $display("FAIL lnk_cnt got free %0d used %0d want 2 2", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_al = 1; b0.i_adata = 16'h0044; cyc();
        b0.i_al = 0;
        checks++; if (b0.o_aaddr !== 16'h5002) begin errors++; $display("FAIL lnk_pop0 got %h want 5002", b0.o_aaddr); end
        b0.i_rd = 1; b0.i_raddr = 16'h5003; cyc();
        b0.i_rd = 0;
        checks++; if (b0.o_rdata !== 16'h0033) begin errors++; $display("FAIL lnk_rd got %h want 0033", b0.o_rdata); end
        b0.i_al = 1; b0.i_adata = 16'h0055; cyc();
        b0.i_al = 0;
        checks++; if (b0.o_aaddr !== 16'h5000) begin errors++; $display("FAIL lnk_pop1 got %h want 5000", b0.o_aaddr); end
        checks++; if (b0.o_free_cnt !== 9'd0 || b0.o_used_cnt !== 9'd4) begin errors++; $display("FAIL lnk_cnt2 got free %0d used %0d want 0 4", b0.o_free_cnt, b0.o_used_cnt); end
        b0.i_rd = 1; b0.i_raddr = 16'h5002; cyc();
        checks++; if (b0.o_rdata !== 16'h0044) begin errors++; $display("FAIL lnk_data0 got %h want 0044", b0.o_rdata); end
        b0.i_raddr = 16'h5000; cyc();
        b0.i_rd = 0;
        checks++; if (b0.o_rdata !== 16'h0055) begin errors++; $display("FAIL lnk_data1 got %h want 0055", b0.o_rdata); end
    endtask

    task automatic test_write();
        b0.i_wr = 1; b0.i_waddr = 16'h5001; b0.i_wdata = 16'hBEEF; cyc();
        b0.i_rd = 1; b0.i_raddr = 16'h5001; b0.i_wdata = 16'h1234; cyc();
        b0.i_wr = 0;
        checks++; if (b0.o_rdata !== 16'hBEEF) begin errors++; $display("FAIL wr_old got %h want beef", b0.o_rdata); end
        cyc();
        b0.i_rd = 0;
        checks++; if (b0.o_rdata !== 16'h1234) begin errors++; $display("FAIL wr_new got %h want 1234", b0.o_rdata); end
        checks++; if (b0.o_err !== 1'b0) begin errors++; $display("FAIL wr_noerr got %b want 0", b0.o_err); end
    endtask

    task automatic test_conflict();
        reset0();
        b0.i_al = 1; b0.i_adata = 16'h0001; b0.i_rd = 1; b0.i_raddr = 16'h5000; cyc();
        idle0();
        checks++; if (b0.o_err !== 1'b1 || b0.o_err_code !== 2'd1) begin errors++; $display("FAIL conflict got err %b code %0d want 1 1", b0.o_err, b0.o_err_code); end
        checks++; if (b0.o_aaddr !== 16'h0) begin errors++; $display("FAIL conflict_aaddr got %h want 0", b0.o_aaddr); end
        b0.i_al = 1; cyc();
        b0.i_al = 0;
        checks++; if (b0.o_aaddr !== 16'h0 || b0.o_used_cnt !== 9'd0) begin errors++; $display("FAIL halted_alloc got aaddr %h used %0d want 0 0", b0.o_aaddr, b0.o_used_cnt); end
        checks++; if (b0.o_err_code !== 2'd1) begin errors++; $display("FAIL halted_code got %0d want 1", b0.o_err_code); end
    endtask

    task automatic test_bad_addr();
        reset0();
        b0.i_fr = 1; b0.i_faddr = 16'h4001; cyc();
        b0.i_fr = 0;
        checks++; if (b0.o_err !== 1'b1 || b0.o_err_code !== 2'd3) begin errors++; $display("FAIL badtag got err %b code %0d want 1 3", b0.o_err, b0.o_err_code); end
        checks++; if (b0.o_free_cnt !== 9'd0) begin errors++; $display("FAIL badtag_free got %0d want 0", b0.o_free_cnt); end
        reset0();
        b0.i_al = 1;
        repeat (3) cyc();
        b0.i_al = 0;
        b0.i_wr = 1; b0.i_waddr = 16'h5005; b0.i_wdata = 16'h00FF; cyc();
        b0.i_wr = 0;
        checks++; if (b0.o_err !== 1'b1 || b0.o_err_code !== 2'd3) begin errors++; $display("FAIL badoff got err %b code %0d want 1 3", b0.o_err, b0.o_err_code); end
        checks++; if (b0.o_used_cnt !== 9'd3) begin errors++; $display("FAIL badoff_used got %0d want 3", b0.o_used_cnt); end
    endtask

    task automatic test_oom();
        rst1 = 1; idle1(); cyc(); rst1 = 0;
        b1.i_al = 1;
        for (int i = 0; i < 7; i++) begin
            b1.i_adata = 16'(i);
            cyc();
            checks++; if (b1.o_aaddr !== 16'(16'h5000 + i)) begin errors++; $display("FAIL oom_alloc%0d got %h want %h", i, b1.o_aaddr, 16'(16'h5000 + i)); end
        end
        checks++; if (b1.o_full !== 1'b0) begin errors++; $display("FAIL oom_notfull got %b want 0", b1.o_full); end
        cyc();
        checks++; if (b1.o_aaddr !== 16'h5007 || b1.o_full !== 1'b1 || b1.o_used_cnt !== 4'd8) begin errors++; $display("FAIL oom_full got aaddr %h full %b used %0d want 5007 1 8", b1.o_aaddr, b1.o_full, b1.o_used_cnt); end
        cyc();
        b1.i_al = 0;
        checks++; if (b1.o_err !== 1'b1 || b1.o_err_code !== 2'd2) begin errors++; $display("FAIL oom_err got err %b code %0d want 1 2", b1.o_err, b1.o_err_code); end
        checks++; if (b1.o_aaddr !== 16'h0 || b1.o_used_cnt !== 4'd8) begin errors++; $display("FAIL oom_state got aaddr %h used %0d want 0 8", b1.o_aaddr, b1.o_used_cnt); end
        b1.i_rd = 1; b1.i_raddr = 16'h5000; cyc();
        b1.i_rd = 0;
        checks++; if (b1.o_err !== 1'b1 || b1.o_err_code !== 2'd2) begin errors++; $display("FAIL oom_sticky got err %b code %0d want 1 2", b1.o_err, b1.o_err_code); end
        rst1 = 1; cyc(); rst1 = 0;
        checks++; if (b1.o_err !== 1'b0 || b1.o_err_code !== 2'd0) begin errors++; $display("FAIL oom_rst_err got err %b code %0d want 0 0", b1.o_err, b1.o_err_code); end
        checks++; if (b1.o_used_cnt !== 4'd0 || b1.o_free_cnt !== 4'd0 || b1.o_full !== 1'b0) begin errors++; $display("FAIL oom_rst_cnt got used %0d free %0d full %b want 0 0 0", b1.o_used_cnt, b1.o_free_cnt, b1.o_full); end
    endtask

    initial begin
        rst0 = 1; rst1 = 1;
        idle0(); idle1();
        test_reset();
        test_alloc();
        test_free_pop();
        test_alloc_free();
        test_link_across_read();
        test_write();
        test_conflict();
        test_bad_addr();
        test_oom();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
